// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset supervisor.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pll_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    DEBOUNCE  = 2'd2,
    RUN       = 2'd3
  } pll_sup_st_t;

  // Default timing parameters
  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT       = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES        = 3;
  localparam int DEF_SYNC_STAGES        = 2;

  // Saturation limits of the status counters
  localparam logic [3:0] RETRY_SAT = 4'd15;
  localparam logic [7:0] LOSS_SAT  = 8'd255;

  // Width of the shared state counter: enough to hold (largest period - 1)
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous active-low reset.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; d is sampled every cycle.
// Ports: clk (destination clock), rst_n (sync reset, low clears chain), d (async in), q (synced out)
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_supervisor.sv
// Drives PLL reset, qualifies PLL lock and sequences the system reset release.
// Latency: SYNC_STAGES+LOCK_STABLE_CYCLES+1 clk_in cycles from stable lock to sys_rst_n=1.
// Backpressure: none; lock loss or reinit_req in RUN restarts the sequence immediately.
// Ports: clk_in/rst_in (ref clock, sync active-low reset), pll_locked (async lock),
//        reinit_req (restart pulse), pll_rst, sys_rst_n, sys_ready, pll_fault,
//        retry_cnt, lock_loss_cnt (status).
module pll_rst_supervisor
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       pll_locked,
  input  logic       reinit_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       sys_ready,
  output logic       pll_fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM   = 4'(MAX_RETRIES);

  logic             lock_s;
  pll_sup_st_t      st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             fault_nxt;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk_in),
    .rst_n (rst_in),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;
    fault_nxt = pll_fault;

    case (st)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          st_nxt  = WAIT_LOCK;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      WAIT_LOCK: begin
        // A lock seen on the timeout cycle wins: no point re-pulsing a PLL that just locked
        if (lock_s) begin
          st_nxt  = DEBOUNCE;
          cnt_nxt = '0;
        end else if (cnt == TO_LAST) begin
          st_nxt  = PLL_RST;
          cnt_nxt = '0;
          if (retry_cnt != RETRY_SAT) retry_nxt = retry_cnt + 4'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        // A lock glitch restarts the wait but is not a timeout, so no retry is charged
        if (!lock_s) begin
          st_nxt  = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == STABLE_LAST) begin
          st_nxt    = RUN;
          cnt_nxt   = '0;
          retry_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      RUN: begin
        // Lock loss takes priority over a simultaneous reinit so it is always counted
        if (!lock_s) begin
          st_nxt  = PLL_RST;
          cnt_nxt = '0;
          if (lock_loss_cnt != LOSS_SAT) loss_nxt = lock_loss_cnt + 8'd1;
        end else if (reinit_req) begin
          st_nxt  = PLL_RST;
          cnt_nxt = '0;
        end
      end

      default: begin
        st_nxt  = PLL_RST;
        cnt_nxt = '0;
      end
    endcase

    // Sticky: only rst_in clears it, retries keep going regardless
    if (retry_nxt >= RETRY_LIM) fault_nxt = 1'b1;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      st            <= PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      sys_ready     <= 1'b0;
      pll_fault     <= 1'b0;
      retry_cnt     <= 4'd0;
      lock_loss_cnt <= 8'd0;
    end else begin
      st            <= st_nxt;
      cnt           <= cnt_nxt;
      pll_rst       <= (st_nxt == PLL_RST);
      sys_rst_n     <= (st_nxt == RUN);
      sys_ready     <= (st_nxt == RUN);
      pll_fault     <= fault_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_pll_rst_supervisor.sv
// Directed self-checking bench for pll_rst_supervisor with shortened timing parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pll_rst_supervisor;

  localparam int S_PLL_RST = 0;
  localparam int S_SYS     = 1;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       pll_locked;
  logic       reinit_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       sys_ready;
  logic       pll_fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int errors = 0;
  int checks = 0;

  pll_rst_supervisor #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .SYNC_STAGES        (2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .pll_locked    (pll_locked),
    .reinit_req    (reinit_req),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .sys_ready     (sys_ready),
    .pll_fault     (pll_fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic sig(input int sel);
    return (sel == S_PLL_RST) ? pll_rst : sys_rst_n;
  endfunction

  // Counts edges until the selected output reaches val; a timeout reports 9999 edges
  task automatic wait_for(input string tag, input int sel, input logic val, input int exp_n);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < exp_n + 50) begin
      tick();
      n++;
      if (sig(sel) == val) hit = 1'b1;
    end
    chk(tag, hit ? n : 9999, exp_n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   pll_rst,       1);
    chk({tag, "_sys_rst_n"}, sys_rst_n,     0);
    chk({tag, "_sys_ready"}, sys_ready,     0);
    chk({tag, "_fault"},     pll_fault,     0);
    chk({tag, "_retry"},     retry_cnt,     0);
    chk({tag, "_loss"},      lock_loss_cnt, 0);
  endtask

  initial begin
    rst_in     = 1'b0;
    pll_locked = 1'b0;
    reinit_req = 1'b0;
    tick_n(3);
    chk_reset_vals("por");

    // 1: first acquisition
    rst_in = 1'b1;
    wait_for("t1_pll_rst_len", S_PLL_RST, 1'b0, 4);
    tick_n(10);
    pll_locked = 1'b1;
    wait_for("t1_release_lat", S_SYS, 1'b1, 11);
    chk("t1_sys_ready", sys_ready, 1);
    chk("t1_retry", retry_cnt, 0);
    chk("t1_pll_rst", pll_rst, 0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    wait_for("t4_drop_lat", S_SYS, 1'b0, 3);
    chk("t4_pll_rst_hi", pll_rst, 1);
    chk("t4_sys_ready", sys_ready, 0);
    chk("t4_loss", lock_loss_cnt, 1);
    wait_for("t4_pll_rst_len", S_PLL_RST, 1'b0, 4);

    // 3: glitch during DEBOUNCE
    pll_locked = 1'b1;
    tick_n(5);
    pll_locked = 1'b0;
    tick_n(3);
    pll_locked = 1'b1;
    chk("t3_sys_rst_n_lo", sys_rst_n, 0);
    wait_for("t3_relock_lat", S_SYS, 1'b1, 11);
    chk("t3_retry", retry_cnt, 0);
    chk("t3_loss", lock_loss_cnt, 1);

    // 5: reinit in RUN, then in WAIT_LOCK
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
    chk("t5_run_sys_rst_n", sys_rst_n, 0);
    chk("t5_run_pll_rst", pll_rst, 1);
    chk("t5_run_loss", lock_loss_cnt, 1);
    wait_for("t5_pll_rst_len", S_PLL_RST, 1'b0, 4);
    reinit_req = 1'b1;
    tick();
    reinit_req = 1'b0;
    chk("t5_wl_pll_rst", pll_rst, 0);
    wait_for("t5_wl_release", S_SYS, 1'b1, 8);
    chk("t5_wl_loss", lock_loss_cnt, 1);

    // 6a: reset mid-RUN
    rst_in     = 1'b0;
    pll_locked = 1'b0;
    tick();
    chk_reset_vals("t6_run");

    // 2: no lock -> retries and fault
    rst_in = 1'b1;
    wait_for("t2_p0_len", S_PLL_RST, 1'b0, 4);
    wait_for("t2_to1", S_PLL_RST, 1'b1, 32);
    chk("t2_retry1", retry_cnt, 1);
    chk("t2_fault1", pll_fault, 0);
    wait_for("t2_p1_len", S_PLL_RST, 1'b0, 4);
    wait_for("t2_to2", S_PLL_RST, 1'b1, 32);
    chk("t2_retry2", retry_cnt, 2);
    chk("t2_fault2", pll_fault, 1);
    wait_for("t2_p2_len", S_PLL_RST, 1'b0, 4);
    wait_for("t2_to3", S_PLL_RST, 1'b1, 32);
    chk("t2_retry3", retry_cnt, 3);
    chk("t2_fault3", pll_fault, 1);
    wait_for("t2_p3_len", S_PLL_RST, 1'b0, 4);
    pll_locked = 1'b1;
    wait_for("t2_release", S_SYS, 1'b1, 11);
    chk("t2_retry_clr", retry_cnt, 0);
    chk("t2_fault_sticky", pll_fault, 1);

    // 6b: reset mid-DEBOUNCE
    pll_locked = 1'b0;
    wait_for("t6_drop_lat", S_SYS, 1'b0, 3);
    chk("t6_loss_pre", lock_loss_cnt, 1);
    wait_for("t6_pll_rst_len", S_PLL_RST, 1'b0, 4);
    pll_locked = 1'b1;
    tick_n(5);
    rst_in = 1'b0;
    tick();
    chk_reset_vals("t6_deb");
    rst_in = 1'b1;
    wait_for("t6_fresh_pulse", S_PLL_RST, 1'b0, 4);
    wait_for("t6_release", S_SYS, 1'b1, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
